// File: rtl/mem_stage_pkg.sv
// Shared opcodes, widths and types for the MEM pipeline stage.
package mem_stage_pkg;
  localparam int OPCODE_W = 5;
  localparam int TAG_W    = 7;
  localparam int DATA_W   = 32;

  localparam logic [OPCODE_W-1:0] OP_NOP = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_LDR = 5'd20;
  localparam logic [OPCODE_W-1:0] OP_STR = 5'd21;

  typedef enum logic [0:0] {IDLE, WAIT} mem_state_t;

  // Instruction identity held while the memory access is in flight.
  typedef struct packed {
    logic [OPCODE_W-1:0] op;
    logic [TAG_W-1:0]    tag;
  } mem_inflight_t;

  function automatic logic isMemOp(input logic [OPCODE_W-1:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory handshake; flags the last allowed cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeoutHit
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable)  cnt <= cnt + CW'(1);
  end

  assign timeoutHit = (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: single-cycle pass-through for ALU ops, req/ack data-memory
// access with upstream stall and timeout abort for loads and stores.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                InValid,
  input  logic [OPCODE_W-1:0] OpCode,
  input  logic [TAG_W-1:0]    CurrentAddress,
  input  logic [DATA_W-1:0]   ResultAlu,
  input  logic [DATA_W-1:0]   StoreData,
  output logic                Stall,
  output logic                MemReq,
  output logic                MemWe,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [DATA_W-1:0]   MemWData,
  input  logic                MemAck,
  input  logic [DATA_W-1:0]   MemRData,
  output logic                ValidOut,
  output logic [OPCODE_W-1:0] OpCodeOut,
  output logic [TAG_W-1:0]    CurrentAddressOut,
  output logic [DATA_W-1:0]   ResultOut,
  output logic                ErrorOut
);
  mem_state_t    state, stateNxt;
  mem_inflight_t inflight;
  logic          isMem, timerHit, timeoutHit, done;

  assign isMem      = InValid && isMemOp(OpCode);
  assign timeoutHit = (state == WAIT) && timerHit && !MemAck;
  assign done       = (state == WAIT) && (MemAck || timerHit);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) uTimer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == IDLE),
    .enable     (state == WAIT),
    .timeoutHit (timerHit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    Stall    = 1'b0;
    case (state)
      IDLE: begin
        Stall = isMem;
        if (isMem) stateNxt = WAIT;
      end
      WAIT: begin
        Stall = !MemAck && !timeoutHit;
        if (done) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
    if (rst) Stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MemReq            <= 1'b0;
      MemWe             <= 1'b0;
      MemAddr           <= '0;
      MemWData          <= '0;
      inflight          <= '0;
      ValidOut          <= 1'b0;
      OpCodeOut         <= '0;
      CurrentAddressOut <= '0;
      ResultOut         <= '0;
      ErrorOut          <= 1'b0;
    end else begin
      ValidOut <= 1'b0;
      case (state)
        IDLE: begin
          if (isMem) begin
            MemReq       <= 1'b1;
            MemWe        <= (OpCode == OP_STR);
            MemAddr      <= ResultAlu[ADDR_W-1:0];
            MemWData     <= StoreData;
            inflight.op  <= OpCode;
            inflight.tag <= CurrentAddress;
          end else if (InValid) begin
            ValidOut          <= 1'b1;
            OpCodeOut         <= OpCode;
            CurrentAddressOut <= CurrentAddress;
            ResultOut         <= ResultAlu;
            ErrorOut          <= 1'b0;
          end
        end
        WAIT: begin
          // Ack wins over a coincident timeout.
          if (done) begin
            MemReq            <= 1'b0;
            ValidOut          <= 1'b1;
            OpCodeOut         <= inflight.op;
            CurrentAddressOut <= inflight.tag;
            ErrorOut          <= !MemAck;
            if (!MemAck)                    ResultOut <= '0;
            else if (inflight.op == OP_LDR) ResultOut <= MemRData;
            else                            ResultOut <= DATA_W'(MemAddr);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
